// File: rtl/line_fill_unit.sv
// Line fill unit: assembles a 128-bit cache line from four 32-bit memory reads
// and drains a single-entry store buffer, with a per-access ack timeout.
`timescale 1ns/1ps
module line_fill_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_req,
  input  logic [15:0]  fill_addr,
  output logic [127:0] fill_line,
  output logic         fill_done,
  output logic         busy,
  input  logic         wr_req,
  input  logic [15:0]  wr_addr,
  input  logic [31:0]  wr_data,
  output logic         wr_accept,
  output logic [15:0]  mem_addr,
  output logic         mem_re,
  output logic         mem_we,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    wait_q, wait_d;
  logic [127:0]  line_q, line_d;
  logic          buf_valid_q, buf_valid_d;
  logic [15:0]   buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          err_q, err_d;
  logic          fill_done_q, fill_done_d;
  logic          busy_q, busy_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          wr_take;
  logic          buf_pending;
  logic [15:0]   eff_addr;
  logic [31:0]   eff_data;
  logic [7:0]    wait_inc;
  logic          timeout;

  // A store captured on the same edge as an IDLE decision already counts as
  // buffered, so it wins over a simultaneous fill request.
  assign wr_take     = wr_req & ~buf_valid_q;
  assign buf_pending = buf_valid_q | wr_take;
  assign eff_addr    = buf_valid_q ? buf_addr_q : wr_addr;
  assign eff_data    = buf_valid_q ? buf_data_q : wr_data;
  assign wait_inc    = wait_q + 8'd1;
  assign timeout     = ((state_q == S_FILL) || (state_q == S_WRITE)) &&
                       !mem_ack && (wait_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (buf_pending)   state_d = S_WRITE;
        else if (fill_req) state_d = S_FILL;
      end
      S_FILL: begin
        if (timeout)                           state_d = S_DONE;
        else if (mem_ack && (idx_q == 2'd3))   state_d = S_DONE;
      end
      S_WRITE: begin
        if (mem_ack || timeout) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    idx_d       = idx_q;
    wait_d      = '0;
    line_d      = line_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    err_d       = err_q | timeout;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (wr_take) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wr_addr;
      buf_data_d  = wr_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (state_d == S_FILL) begin
          base_d = {fill_addr[15:2], 2'b00};
          idx_d  = '0;
          line_d = '0;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          line_d[{idx_q, 5'b00000} +: 32] = mem_rdata;
          idx_d = idx_q + 2'd1;
        end else if (!timeout) begin
          wait_d = wait_inc;
        end
      end
      S_WRITE: begin
        if (mem_ack || timeout) buf_valid_d = 1'b0;
        else                    wait_d      = wait_inc;
      end
      default: ;
    endcase

    if (state_d == S_FILL) begin
      mem_addr_d = {base_d[15:2], idx_d};
    end else if (state_d == S_WRITE) begin
      mem_addr_d  = eff_addr;
      mem_wdata_d = eff_data;
    end

    mem_re_d    = (state_d == S_FILL);
    mem_we_d    = (state_d == S_WRITE);
    fill_done_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q      <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      line_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      err_q       <= 1'b0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      base_q      <= base_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      line_q      <= line_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      err_q       <= err_d;
      fill_done_q <= fill_done_d;
      busy_q      <= busy_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign fill_line = line_q;
  assign fill_done = fill_done_q;
  assign busy      = busy_q;
  assign wr_accept = ~buf_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed scenarios plus randomized
// fills/stores checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_line_fill_unit;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic [127:0] fill_line;
  logic         fill_done;
  logic         busy;
  logic         wr_req;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_accept;
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  bit err_exp  = 1'b0;

  line_fill_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_line(fill_line),
    .fill_done(fill_done), .busy(busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_accept(wr_accept),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [15:0] a, input logic [31:0] key);
    return ({16'h0, a} * 32'd3) ^ key;
  endfunction

  // One line fill; dly[w] = no-ack cycles before word w is acked (>= TMO: never).
  // store_cyc > 0 injects a store in that fill cycle and a rejected one after it.
  task automatic do_fill(input logic [15:0] addr, input int dly[4], input logic [31:0] key,
                         input int store_cyc, input logic [15:0] saddr, input logic [31:0] sdata);
    logic [127:0] exp_line = '0;
    logic [15:0]  base = {addr[15:2], 2'b00};
    int cyc = 0;
    bit aborted = 1'b0;
    fill_req  = 1'b1;
    fill_addr = addr;
    for (int w = 0; w < 4; w++) begin
      bit to = (dly[w] >= TMO);
      int n  = to ? TMO : dly[w] + 1;
      if (aborted) break;
      for (int c = 0; c < n; c++) begin
        tick();
        cyc++;
        fill_addr = 16'($urandom);
        chk("fill_re", mem_re, 1);
        chk("fill_we", mem_we, 0);
        chk("fill_addr", mem_addr, base + 16'(w));
        chk("fill_busy", busy, 1);
        chk("fill_nodone", fill_done, 0);
        if (store_cyc > 0 && cyc == store_cyc) begin
          chk("store_acc", wr_accept, 1);
          wr_req = 1'b1; wr_addr = saddr; wr_data = sdata;
        end else if (store_cyc > 0 && cyc == store_cyc + 1) begin
          chk("store_full", wr_accept, 0);
          wr_req = 1'b1; wr_addr = ~saddr; wr_data = ~sdata;
        end else begin
          wr_req = 1'b0;
        end
        if (!to && c == n - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mdata(base + 16'(w), key);
          exp_line[w*32 +: 32] = mem_rdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end
      if (to) begin
        aborted = 1'b1;
        err_exp = 1'b1;
      end
    end
    tick();
    mem_ack = 1'b0;
    wr_req  = 1'b0;
    chk("done_pulse", fill_done, 1);
    chk("done_line", fill_line, exp_line);
    chk("done_re", mem_re, 0);
    chk("done_busy", busy, 1);
    chk("done_err", err, err_exp);
    fill_req = 1'b0;
    tick();
    chk("post_done", fill_done, 0);
    chk("post_busy", busy, 0);
    chk("post_line", fill_line, exp_line);
    chk("post_acc", wr_accept, (store_cyc == 0));
  endtask

  // One store drain; drive=0 means the store is already buffered.
  task automatic do_write(input logic [15:0] a, input logic [31:0] dat, input int dly,
                          input bit drive, input bit with_fill);
    bit to = (dly >= TMO);
    int n  = to ? TMO : dly + 1;
    if (drive) begin
      chk("wr_acc_idle", wr_accept, 1);
      wr_req = 1'b1; wr_addr = a; wr_data = dat;
      if (with_fill) begin
        fill_req  = 1'b1;
        fill_addr = 16'($urandom);
      end
    end
    for (int c = 0; c < n; c++) begin
      tick();
      wr_req = 1'b0;
      chk("wr_we", mem_we, 1);
      chk("wr_re", mem_re, 0);
      chk("wr_addr", mem_addr, a);
      chk("wr_data", mem_wdata, dat);
      chk("wr_acc_busy", wr_accept, 0);
      chk("wr_busy", busy, 1);
      mem_ack   = (!to && c == n - 1);
      mem_rdata = $urandom;
    end
    if (to) err_exp = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_end_we", mem_we, 0);
    chk("wr_end_acc", wr_accept, 1);
    chk("wr_end_busy", busy, 0);
    chk("wr_end_re", mem_re, 0);
    chk("wr_end_err", err, err_exp);
  endtask

  task automatic check_reset_outputs();
    chk("rst_line", fill_line, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_acc", wr_accept, 1);
  endtask

  initial begin
    int d[4];
    reset = 1'b0; fill_req = 1'b0; fill_addr = '0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();

    d = '{0, 0, 0, 0};
    do_fill(16'h1237, d, 32'h0, 0, '0, '0);
    d = '{2, 2, 2, 2};
    do_fill(16'hA5F1, d, 32'h0, 0, '0, '0);

    do_write(16'h0040, 32'hDEADBEEF, 0, 1'b1, 1'b1);
    d = '{0, 1, 0, 1};
    do_fill(16'h2222, d, 32'h1111_0000, 0, '0, '0);

    d = '{0, 0, 0, 0};
    do_fill(16'h0800, d, 32'h5A5A_5A5A, 2, 16'h0123, 32'hCAFEF00D);
    do_write(16'h0123, 32'hCAFEF00D, 0, 1'b0, 1'b0);

    do_write(16'h7777, 32'h0BAD_F00D, TMO - 1, 1'b1, 1'b0);

    d = '{0, 0, TMO, 0};
    do_fill(16'h4448, d, 32'h0, 0, '0, '0);
    d = '{1, 0, 0, 0};
    do_fill(16'h3000, d, 32'h0, 0, '0, '0);
    do_write(16'h0F0F, 32'h1234_5678, TMO, 1'b1, 1'b0);

    // Reset during word 1 with a store buffered: everything is dropped.
    fill_req = 1'b1; fill_addr = 16'h5550;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    wr_req = 1'b1; wr_addr = 16'h9999; wr_data = 32'h9999_9999;
    tick();
    mem_ack = 1'b0; wr_req = 1'b0;
    chk("pre_rst_addr", mem_addr, 16'h5551);
    tick();
    #2 reset = 1'b0;
    #1;
    check_reset_outputs();
    err_exp = 1'b0;
    fill_req = 1'b0;
    tick(); tick();
    chk("rst_hold_done", fill_done, 0);
    reset = 1'b1;
    tick();
    chk("rst_rel_we", mem_we, 0);
    chk("rst_rel_busy", busy, 0);
    d = '{0, 1, 2, 0};
    do_fill(16'h5553, d, 32'h0, 0, '0, '0);

    for (int it = 0; it < 20; it++) begin
      int op = $urandom_range(0, 3);
      logic [15:0] a  = 16'($urandom);
      logic [15:0] wa = 16'($urandom);
      logic [31:0] wd = $urandom;
      logic [31:0] k  = $urandom;
      for (int w = 0; w < 4; w++) d[w] = $urandom_range(0, TMO - 1);
      case (op)
        0: do_fill(a, d, k, 0, '0, '0);
        1: do_write(wa, wd, $urandom_range(0, TMO - 1), 1'b1, 1'b0);
        2: begin
          do_write(wa, wd, $urandom_range(0, TMO - 1), 1'b1, 1'b1);
          do_fill(a, d, k, 0, '0, '0);
        end
        default: begin
          do_fill(a, d, k, 2, wa, wd);
          do_write(wa, wd, $urandom_range(0, TMO - 1), 1'b0, 1'b0);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (mem_re && mem_we) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_excl: mem_re=%0b mem_we=%0b required not both 1", mem_re, mem_we);
    end
  end

endmodule
